// File: rtl/hazard_fwd_ctrl_if.sv
// ----------------------------------------------------------------------------
// hazard_fwd_ctrl_if
// Purpose : bundles the pipeline-side signals of the forwarding / hazard
//           controller. The pipeline (master) drives the stage register
//           addresses and control bits. The controller (slave) returns the
//           bypass selects, stall/flush, mult/div busy and stall statistics.
// Signals : stat_clr                          statistics clear
//           id_*  (rs, rt, use_rs, use_rt, is_br, is_sw, md, rd_hilo)
//           ex_*  (rs, rt, wr, regwrite, memtoreg, md_start)
//           mem_* (wr, rt, regwrite, memtoreg, memwrite)
//           wb_*  (wr, regwrite)
//           outputs: id_fwd1/2, ex_fwd_a/b (0 regfile, 1 MEM, 2 WB),
//           mem_fwd_wm, stall, ex_flush, md_busy, stall_cnt
// ----------------------------------------------------------------------------
interface hazard_fwd_ctrl_if #(
  parameter int AW    = 5,
  parameter int CNT_W = 16
);
  logic             stat_clr;
  logic [AW-1:0]    id_rs;
  logic [AW-1:0]    id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             id_is_br;
  logic             id_is_sw;
  logic             id_md;
  logic             id_rd_hilo;
  logic [AW-1:0]    ex_rs;
  logic [AW-1:0]    ex_rt;
  logic [AW-1:0]    ex_wr;
  logic             ex_regwrite;
  logic             ex_memtoreg;
  logic             ex_md_start;
  logic [AW-1:0]    mem_wr;
  logic [AW-1:0]    mem_rt;
  logic             mem_regwrite;
  logic             mem_memtoreg;
  logic             mem_memwrite;
  logic [AW-1:0]    wb_wr;
  logic             wb_regwrite;
  logic [1:0]       id_fwd1;
  logic [1:0]       id_fwd2;
  logic [1:0]       ex_fwd_a;
  logic [1:0]       ex_fwd_b;
  logic             mem_fwd_wm;
  logic             stall;
  logic             ex_flush;
  logic             md_busy;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output stat_clr, id_rs, id_rt, id_use_rs, id_use_rt, id_is_br, id_is_sw,
           id_md, id_rd_hilo, ex_rs, ex_rt, ex_wr, ex_regwrite, ex_memtoreg,
           ex_md_start, mem_wr, mem_rt, mem_regwrite, mem_memtoreg,
           mem_memwrite, wb_wr, wb_regwrite,
    input  id_fwd1, id_fwd2, ex_fwd_a, ex_fwd_b, mem_fwd_wm, stall, ex_flush,
           md_busy, stall_cnt
  );

  modport slave (
    input  stat_clr, id_rs, id_rt, id_use_rs, id_use_rt, id_is_br, id_is_sw,
           id_md, id_rd_hilo, ex_rs, ex_rt, ex_wr, ex_regwrite, ex_memtoreg,
           ex_md_start, mem_wr, mem_rt, mem_regwrite, mem_memtoreg,
           mem_memwrite, wb_wr, wb_regwrite,
    output id_fwd1, id_fwd2, ex_fwd_a, ex_fwd_b, mem_fwd_wm, stall, ex_flush,
           md_busy, stall_cnt
  );
endinterface

// File: rtl/hazard_fwd_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_fwd_ctrl
// Purpose : forwarding and hazard controller for a 5-stage MIPS pipeline.
//           Selects bypass sources for ID (branch/jr compare), EX (ALU
//           operands) and MEM (sw data). Detects load-use, branch and
//           mult/div hazards. Tracks the multi-cycle mult/div unit with a
//           latency counter and keeps a saturating stalled-cycle counter.
// Ports   : clk  rising-edge clock
//           rst  synchronous active-high reset
//           bus  hazard_fwd_ctrl_if.slave (pipeline stage info in,
//                bypass selects / stall / flush / md_busy / stall_cnt out)
// Params  : AW     register address width (address 0 is hardwired zero)
//           MD_LAT mult/div busy cycles after start (1..15)
//           CNT_W  width of the stall statistics counter
// ----------------------------------------------------------------------------
module hazard_fwd_ctrl #(
  parameter int AW     = 5,
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  hazard_fwd_ctrl_if.slave   bus
);

  localparam logic [3:0] MD_LOAD = 4'(MD_LAT);

  logic [3:0]       r_md_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  // A producer can only be matched if it writes a real register.
  logic w_ex_prod;
  logic w_mem_prod;
  logic w_wb_prod;
  assign w_ex_prod  = bus.ex_regwrite  && (bus.ex_wr  != '0);
  assign w_mem_prod = bus.mem_regwrite && (bus.mem_wr != '0);
  assign w_wb_prod  = bus.wb_regwrite  && (bus.wb_wr  != '0);

  // Source operands indexed 0 = rs, 1 = rt.
  logic [AW-1:0] w_id_src [2];
  logic [AW-1:0] w_ex_src [2];
  logic          w_id_use [2];
  logic          w_lu_use [2];
  logic [1:0]    w_id_fwd [2];
  logic [1:0]    w_ex_fwd [2];
  logic          w_lu_hit [2];
  logic          w_br_hit [2];

  // A plain sw only needs rt at MEM, where it can still be bypassed from WB,
  // so its rt does not create a load-use hazard.
  logic w_rt_data_only;
  assign w_rt_data_only = bus.id_is_sw && !bus.id_is_br;

  assign w_id_src[0] = bus.id_rs;
  assign w_id_src[1] = bus.id_rt;
  assign w_ex_src[0] = bus.ex_rs;
  assign w_ex_src[1] = bus.ex_rt;
  assign w_id_use[0] = bus.id_use_rs;
  assign w_id_use[1] = bus.id_use_rt;
  assign w_lu_use[0] = bus.id_use_rs;
  assign w_lu_use[1] = bus.id_use_rt && !w_rt_data_only;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      logic w_ex_mem_hit;
      logic w_ex_wb_hit;
      logic w_id_ex_hit;
      logic w_id_mem_hit;
      logic w_id_wb_hit;

      assign w_ex_mem_hit = w_mem_prod && (bus.mem_wr == w_ex_src[gi]);
      assign w_ex_wb_hit  = w_wb_prod  && (bus.wb_wr  == w_ex_src[gi]);
      assign w_id_ex_hit  = w_ex_prod  && (bus.ex_wr  == w_id_src[gi]);
      assign w_id_mem_hit = w_mem_prod && (bus.mem_wr == w_id_src[gi]);
      assign w_id_wb_hit  = w_wb_prod  && (bus.wb_wr  == w_id_src[gi]);

      // A lw in MEM has no data yet, so it cannot bypass; fall back to WB.
      assign w_ex_fwd[gi] = (w_ex_mem_hit && !bus.mem_memtoreg) ? 2'd1 :
                            w_ex_wb_hit                         ? 2'd2 : 2'd0;

      assign w_id_fwd[gi] = !bus.id_is_br                       ? 2'd0 :
                            (w_id_mem_hit && !bus.mem_memtoreg) ? 2'd1 :
                            w_id_wb_hit                         ? 2'd2 : 2'd0;

      assign w_lu_hit[gi] = w_lu_use[gi] && w_id_ex_hit && bus.ex_memtoreg;

      // Branches resolve in ID: any EX producer, or a lw still in MEM,
      // is too late to bypass.
      assign w_br_hit[gi] = w_id_use[gi] &&
                            (w_id_ex_hit || (w_id_mem_hit && bus.mem_memtoreg));
    end
  endgenerate

  logic w_s_lu;
  logic w_s_br;
  logic w_s_md;
  logic w_md_busy;
  logic w_stall;

  assign w_md_busy = (r_md_cnt != 4'd0);
  assign w_s_lu    = w_lu_hit[0] || w_lu_hit[1];
  assign w_s_br    = bus.id_is_br && (w_br_hit[0] || w_br_hit[1]);
  assign w_s_md    = (bus.id_md || bus.id_rd_hilo) && (w_md_busy || bus.ex_md_start);
  assign w_stall   = w_s_lu || w_s_br || w_s_md;

  // Mult/div latency counter; a start while busy is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_md_cnt <= 4'd0;
    end else if (!w_md_busy && bus.ex_md_start) begin
      r_md_cnt <= MD_LOAD;
    end else if (w_md_busy) begin
      r_md_cnt <= r_md_cnt - 4'd1;
    end
  end

  // Saturating stalled-cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (bus.stat_clr) begin
      r_stall_cnt <= '0;
    end else if (w_stall && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign bus.id_fwd1    = w_id_fwd[0];
  assign bus.id_fwd2    = w_id_fwd[1];
  assign bus.ex_fwd_a   = w_ex_fwd[0];
  assign bus.ex_fwd_b   = w_ex_fwd[1];
  assign bus.mem_fwd_wm = bus.mem_memwrite && w_wb_prod && (bus.wb_wr == bus.mem_rt);
  assign bus.stall      = w_stall;
  assign bus.ex_flush   = w_stall;
  assign bus.md_busy    = w_md_busy;
  assign bus.stall_cnt  = r_stall_cnt;

endmodule
